dmem_byte_responder: RTL and testbench

- Data-memory responder at the far end of the CPU's 8-bit memory-address path.
- Accepts a 32-bit word read or write request at an 8-bit byte address.
- Serves the request from a 256 x 8 byte-wide storage array, one byte per cycle, little-endian.
- Signals completion with a one-cycle ack and flags misaligned addresses without touching storage.

---
 rtl/dmem_byte_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_byte_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_responder.sv
// rtl/dmem_byte_responder.sv - word-access responder over a byte-wide data memory
//
// Serves 32-bit little-endian word reads/writes from a 2**ADDR_W x 8 storage
// array, one byte per cycle. Misaligned requests are answered with an error
// pulse and never touch storage.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous reset, active low
//   req       request strobe, sampled only in IDLE
//   we        1 = word write, 0 = word read (sampled with req)
//   memaddr   byte address of the word (sampled with req)
//   wdata     write data (sampled with req)
//   rdata     last completed read word
//   ack       one-cycle completion pulse
//   busy      high from the accept edge until the edge returning to IDLE
//   addr_err  one-cycle misaligned-request flag, coincident with ack

module dmem_byte_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [1:0]          beat_q,   beat_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                we_q,     we_d;
  logic                err_q,    err_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;

  // Storage is deliberately not reset: contents must survive rst_n.
  logic [7:0]          mem_q [0:(1<<ADDR_W)-1];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wbyte;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    we_d      = we_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    // Alignment guarantees addr_q + beat never wraps past the top byte.
    mem_addr  = addr_q + ADDR_W'(beat_q);
    mem_wbyte = wdata_q[8*beat_q +: 8];

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = memaddr;
          we_d    = we;
          wdata_d = wdata;
          beat_d  = 2'd0;
          if (memaddr[1:0] == 2'b00) begin
            err_d   = 1'b0;
            state_d = XFER;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      XFER: begin
        if (we_q) begin
          mem_we = 1'b1;
        end else begin
          shadow_d[8*beat_q +: 8] = mem_q[mem_addr];
        end
        if (beat_q == 2'd3) begin
          state_d = RESP;
          // Publish including the final byte so rdata is valid alongside ack.
          if (!we_q) begin
            rdata_d = shadow_d;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wbyte;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = (state_q == RESP);
  assign busy     = (state_q != IDLE);
  assign addr_err = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dmem_byte_responder.sv
// tb/tb_dmem_byte_responder.sv - randomized self-checking bench for dmem_byte_responder

module tb_dmem_byte_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [7:0]  memaddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  mem_m [0:255];
  logic [31:0] rdata_m;

  dmem_byte_responder #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .memaddr  (memaddr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] a);
    return {mem_m[a + 8'd3], mem_m[a + 8'd2], mem_m[a + 8'd1], mem_m[a]};
  endfunction

  // Spec-level effect of one completed access on the reference state.
  task automatic model_apply(input logic w, input logic [7:0] a, input logic [31:0] d);
    if (a[1:0] == 2'b00) begin
      if (w) begin
        for (int i = 0; i < 4; i++) mem_m[a + 8'(i)] = d[8*i +: 8];
      end else begin
        rdata_m = model_word(a);
      end
    end
  endtask

  // Issue one request; optionally pulse a conflicting request while busy,
  // or abort with reset at negedge number abort_at after acceptance.
  task automatic run_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                            input bit noise, input int abort_at);
    int cyc;
    int acks;
    bit seen;
    bit exp_err;
    exp_err = (a[1:0] != 2'b00);
    req = 1'b1; we = w; memaddr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    req = 1'b0; we = 1'($urandom); memaddr = 8'($urandom); wdata = $urandom;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {31'd0, addr_err}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        // Beats completed at edges E1..E(abort_at-1) have landed in storage.
        if (w && !exp_err)
          for (int i = 0; i < abort_at - 1 && i < 4; i++) mem_m[a + 8'(i)] = d[8*i +: 8];
        rdata_m = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        return;
      end
      if (noise && cyc == 2) begin
        req = 1'b1; we = 1'b1; memaddr = 8'h10; wdata = 32'h0;
      end else if (noise && cyc == 3) begin
        req = 1'b0;
      end
      check("busy", {31'd0, busy}, 32'd1);
      if (ack) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    req = 1'b0;
    check("ack_seen", {31'd0, seen}, 32'd1);
    check("latency", 32'(cyc), exp_err ? 32'd1 : 32'd5);
    check("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
    model_apply(w, a, d);
    check("rdata", rdata, rdata_m);
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (i == 0) check("busy_release", {31'd0, busy}, 32'd0);
    end
    check("single_ack", 32'(acks), 32'd0);
  endtask

  initial begin
    int gap;
    int waitc;
    logic [7:0] ra;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; memaddr = 8'h0; wdata = 32'h0;
    rdata_m = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Give every byte a known value; storage itself has no reset.
    for (int i = 0; i < 64; i++) run_access(1'b1, 8'(i * 4), $urandom, 1'b0, 0);

    // Aligned write then read
    run_access(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 0);
    run_access(1'b0, 8'h10, 32'h0, 1'b0, 0);
    check("dir_read_10", rdata, 32'hDEADBEEF);

    // Top of address space
    run_access(1'b1, 8'hFC, 32'h01020304, 1'b0, 0);
    run_access(1'b0, 8'hFC, 32'h0, 1'b0, 0);
    check("dir_read_fc", rdata, 32'h01020304);
    run_access(1'b0, 8'h00, 32'h0, 1'b0, 0);

    // Misaligned write leaves storage and rdata alone
    run_access(1'b0, 8'h10, 32'h0, 1'b0, 0);
    run_access(1'b1, 8'h21, 32'hFFFFFFFF, 1'b0, 0);
    check("mis_rdata_hold", rdata, 32'hDEADBEEF);
    run_access(1'b0, 8'h20, 32'h0, 1'b0, 0);

    // Conflicting request while busy is ignored
    run_access(1'b0, 8'h10, 32'h0, 1'b1, 0);
    check("busy_ignore_rdata", rdata, 32'hDEADBEEF);
    run_access(1'b0, 8'h10, 32'h0, 1'b0, 0);
    check("busy_ignore_mem", rdata, 32'hDEADBEEF);

    // Reset in the middle of a write, after beats 0 and 1
    run_access(1'b1, 8'h40, 32'h0, 1'b0, 0);
    run_access(1'b1, 8'h40, 32'hAABBCCDD, 1'b0, 3);
    run_access(1'b0, 8'h40, 32'h0, 1'b0, 0);
    check("abort_partial", rdata, 32'h0000CCDD);

    // Back-to-back reads with req held high
    req = 1'b1; we = 1'b0; memaddr = 8'h10;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!ack && waitc < 20);
    check("b2b_ack1", {31'd0, ack}, 32'd1);
    check("b2b_rdata1", rdata, model_word(8'h10));
    memaddr = 8'hFC;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 2) req = 1'b0;
    end while (!ack && gap < 20);
    req = 1'b0;
    check("b2b_gap", 32'(gap), 32'd6);
    rdata_m = model_word(8'hFC);
    check("b2b_rdata2", rdata, rdata_m);
    repeat (2) @(negedge clk);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
      run_access(1'($urandom), ra, $urandom, 1'($urandom_range(3) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
